// File: rtl/seg_scan_ctrl_if.sv
// Handshake and display bus between a host and the 4-digit scan controller.
// The master supplies display data and load requests; the slave drives the decoder and anodes.
interface seg_scan_ctrl_if;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic [3:0]  en_in;
    logic        load;
    logic        load_ack;
    logic [3:0]  dec_d;
    logic        dec_point;
    logic        dec_le;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_start;

    modport master (
        output hex_in, dp_in, en_in, load,
        input  load_ack, dec_d, dec_point, dec_le, an, digit_idx, frame_start
    );

    modport slave (
        input  hex_in, dp_in, en_in, load,
        output load_ack, dec_d, dec_point, dec_le, an, digit_idx, frame_start
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scans one shared hex-to-7-seg decoder across a 4-digit common-anode display,
// with a per-slot blanking gap and frame-synchronous load/ack of new display data.
//
//   state    | meaning
//   ST_BLANK | all anodes off, decoder LE high (anti-ghosting gap at slot start)
//   ST_SHOW  | anode of digit_idx on, decoder fed from the shadow set
module seg_scan_ctrl #(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t      state, state_nxt;
    logic        run;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]  idx, idx_nxt;
    logic        pend, pend_nxt;
    logic [15:0] stg_hex, stg_hex_nxt, sh_hex, sh_hex_nxt;
    logic [3:0]  stg_dp, stg_dp_nxt, sh_dp, sh_dp_nxt;
    logic [3:0]  stg_en, stg_en_nxt, sh_en, sh_en_nxt;
    logic [3:0]  an_nxt, dec_d_nxt;
    logic        dec_point_nxt, dec_le_nxt, ack_nxt, fs_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_BLANK;
        else        state <= state_nxt;
    end

    // Outputs are registered from next-cycle values so they line up with cnt/digit_idx.
    always_comb begin
        cnt_nxt       = '0;
        idx_nxt       = '0;
        state_nxt     = state;
        stg_hex_nxt   = stg_hex;
        stg_dp_nxt    = stg_dp;
        stg_en_nxt    = stg_en;
        pend_nxt      = pend;
        sh_hex_nxt    = sh_hex;
        sh_dp_nxt     = sh_dp;
        sh_en_nxt     = sh_en;
        ack_nxt       = 1'b0;
        an_nxt        = 4'b1111;
        dec_d_nxt     = 4'h0;
        dec_point_nxt = 1'b0;
        dec_le_nxt    = 1'b1;

        // The first cycle after reset release is slot 0, count 0 (a frame start).
        if (run) begin
            cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            idx_nxt = (cnt == CNT_LAST) ? idx + 2'd1 : idx;
        end

        case (state)
            ST_BLANK: if (cnt_nxt >= BLANK_END) state_nxt = ST_SHOW;
            ST_SHOW:  if (cnt_nxt <  BLANK_END) state_nxt = ST_BLANK;
            default:  state_nxt = ST_BLANK;
        endcase

        if (bus.load) begin
            stg_hex_nxt = bus.hex_in;
            stg_dp_nxt  = bus.dp_in;
            stg_en_nxt  = bus.en_in;
            pend_nxt    = 1'b1;
        end

        fs_nxt = (cnt_nxt == '0) && (idx_nxt == 2'd0);
        if (fs_nxt && pend_nxt) begin
            sh_hex_nxt = stg_hex_nxt;
            sh_dp_nxt  = stg_dp_nxt;
            sh_en_nxt  = stg_en_nxt;
            pend_nxt   = 1'b0;
            ack_nxt    = 1'b1;
        end

        if (state_nxt == ST_SHOW) begin
            an_nxt        = ~(4'b0001 << idx_nxt);
            dec_d_nxt     = sh_hex_nxt[{idx_nxt, 2'b00} +: 4];
            dec_point_nxt = sh_dp_nxt[idx_nxt];
            dec_le_nxt    = ~sh_en_nxt[idx_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run             <= 1'b0;
            cnt             <= '0;
            idx             <= 2'd0;
            pend            <= 1'b0;
            stg_hex         <= '0;
            stg_dp          <= '0;
            stg_en          <= '0;
            sh_hex          <= '0;
            sh_dp           <= '0;
            sh_en           <= '0;
            bus.an          <= 4'b1111;
            bus.dec_le      <= 1'b1;
            bus.dec_d       <= 4'h0;
            bus.dec_point   <= 1'b0;
            bus.load_ack    <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.digit_idx   <= 2'd0;
        end else begin
            run             <= 1'b1;
            cnt             <= cnt_nxt;
            idx             <= idx_nxt;
            pend            <= pend_nxt;
            stg_hex         <= stg_hex_nxt;
            stg_dp          <= stg_dp_nxt;
            stg_en          <= stg_en_nxt;
            sh_hex          <= sh_hex_nxt;
            sh_dp           <= sh_dp_nxt;
            sh_en           <= sh_en_nxt;
            bus.an          <= an_nxt;
            bus.dec_le      <= dec_le_nxt;
            bus.dec_d       <= dec_d_nxt;
            bus.dec_point   <= dec_point_nxt;
            bus.load_ack    <= ack_nxt;
            bus.frame_start <= fs_nxt;
            bus.digit_idx   <= idx_nxt;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: per-cycle reference check, load scoreboard,
// a table of display vectors and hand-written handshake/reset sequences.
module tb_seg_scan_ctrl;
    localparam int TD = 8;
    localparam int BC = 2;
    localparam int FR = 4 * TD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_ctrl_if bus();

    seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  en;
    } dset_t;

    typedef struct {
        dset_t      din;
        logic [3:0] exp_d [4];
        logic [3:0] exp_pt;
        logic [3:0] exp_le;
    } vec_t;

    dset_t sb_q[$];
    dset_t m_sh;
    bit    m_run, m_pend, m_ack;
    int    m_pos;
    int    checks = 0;
    int    failures = 0;
    int    ack_seen = 0;
    vec_t  vecs [3];
    logic [3:0] an_exp [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic dset_t cur_in();
        dset_t d;
        d.hex = bus.hex_in;
        d.dp  = bus.dp_in;
        d.en  = bus.en_in;
        return d;
    endfunction

    // Reference for what the DUT must present after the coming edge.
    function automatic void model_edge();
        if (!rst_n) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_pend = 1'b0;
            m_ack  = 1'b0;
            m_sh   = '{16'h0, 4'h0, 4'h0};
            sb_q.delete();
        end else begin
            if (!m_run) begin
                m_run = 1'b1;
                m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FR;
            end
            if (bus.load) begin
                if (m_pend) sb_q[sb_q.size() - 1] = cur_in();
                else begin
                    sb_q.push_back(cur_in());
                    m_pend = 1'b1;
                end
            end
            m_ack = (m_pos == 0) && m_pend;
            if (m_ack) m_pend = 1'b0;
        end
    endfunction

    task automatic check_cycle();
        logic [13:0] act, exp, mask;
        int cnt, idx;
        if (bus.load_ack === 1'b1) begin
            ack_seen++;
            if (sb_q.size() == 0) chk("ack_without_load", 32'(bus.load_ack), 32'd0);
            else m_sh = sb_q.pop_front();
        end
        act = {bus.an, bus.dec_le, bus.digit_idx, bus.frame_start, bus.load_ack, bus.dec_d, bus.dec_point};
        mask = '1;
        if (!m_run) begin
            exp = {4'b1111, 1'b1, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0};
        end else begin
            cnt = m_pos % TD;
            idx = m_pos / TD;
            if (cnt < BC) begin
                exp  = {4'b1111, 1'b1, 2'(idx), m_pos == 0, m_ack, 4'h0, 1'b0};
                mask = 14'b11111111_00000_0 | 14'h3FE0;
            end else begin
                exp = {~(4'b0001 << idx), ~m_sh.en[idx], 2'(idx), 1'b0, m_ack,
                       4'((m_sh.hex >> (4 * idx)) & 16'hF), m_sh.dp[idx]};
            end
        end
        chk("cycle_outputs", 32'(act & mask), 32'(exp & mask));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #2;
        check_cycle();
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (!(m_run && m_pos == p)) begin
            if (n > FR + 4) begin
                checks++;
                failures++;
                $display("FAIL wait_pos_timeout: actual=%0d expected=%0d", m_pos, p);
                return;
            end
            cyc();
            n++;
        end
    endtask

    task automatic load_once(input logic [15:0] hex, input logic [3:0] dp, input logic [3:0] en);
        bus.hex_in = hex;
        bus.dp_in  = dp;
        bus.en_in  = en;
        bus.load   = 1'b1;
        cyc();
        bus.load   = 1'b0;
    endtask

    initial begin
        int a0, n_a, n_b;
        an_exp[0] = 4'b1110; an_exp[1] = 4'b1101; an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;

        vecs[0].din = '{16'h4321, 4'b0101, 4'b1111};
        vecs[0].exp_d[0] = 4'h1; vecs[0].exp_d[1] = 4'h2; vecs[0].exp_d[2] = 4'h3; vecs[0].exp_d[3] = 4'h4;
        vecs[0].exp_pt = 4'b0101; vecs[0].exp_le = 4'b0000;
        vecs[1].din = '{16'h4321, 4'b0000, 4'b1011};
        vecs[1].exp_d[0] = 4'h1; vecs[1].exp_d[1] = 4'h2; vecs[1].exp_d[2] = 4'h3; vecs[1].exp_d[3] = 4'h4;
        vecs[1].exp_pt = 4'b0000; vecs[1].exp_le = 4'b0100;
        vecs[2].din = '{16'hBEEF, 4'b1000, 4'b0110};
        vecs[2].exp_d[0] = 4'hF; vecs[2].exp_d[1] = 4'hE; vecs[2].exp_d[2] = 4'hE; vecs[2].exp_d[3] = 4'hB;
        vecs[2].exp_pt = 4'b1000; vecs[2].exp_le = 4'b1001;

        bus.hex_in = '0;
        bus.dp_in  = '0;
        bus.en_in  = '0;
        bus.load   = 1'b0;

        // Reset and release
        rst_n = 1'b0;
        repeat (5) cyc();
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_le", 32'(bus.dec_le), 32'd1);
        rst_n = 1'b1;
        cyc();
        chk("first_frame_start", 32'(bus.frame_start), 32'd1);
        wait_pos(TD + 4);
        chk("dark_after_reset", 32'(bus.dec_le), 32'd1);

        // Table of display vectors
        foreach (vecs[v]) begin
            wait_pos(5);
            load_once(vecs[v].din.hex, vecs[v].din.dp, vecs[v].din.en);
            wait_pos(0);
            chk("vec_ack", 32'(bus.load_ack), 32'd1);
            for (int k = 0; k < 4; k++) begin
                wait_pos(k * TD + 4);
                chk("vec_an", 32'(bus.an), 32'(an_exp[k]));
                chk("vec_d", 32'(bus.dec_d), 32'(vecs[v].exp_d[k]));
                chk("vec_pt", 32'(bus.dec_point), 32'(vecs[v].exp_pt[k]));
                chk("vec_le", 32'(bus.dec_le), 32'(vecs[v].exp_le[k]));
            end
        end

        // Last load wins, shadow only changes at the frame boundary
        wait_pos(TD + 2);
        a0 = ack_seen;
        load_once(16'hAAAA, 4'h0, 4'hF);
        wait_pos(3 * TD + 2);
        load_once(16'hBBBB, 4'h0, 4'hF);
        wait_pos(0);
        chk("lastwin_ack", 32'(bus.load_ack), 32'd1);
        n_a = 0;
        n_b = 0;
        for (int i = 1; i < FR; i++) begin
            cyc();
            if (bus.an != 4'hF && bus.dec_d == 4'hA) n_a++;
            if (bus.an != 4'hF && bus.dec_d == 4'hB) n_b++;
        end
        chk("lastwin_no_a", 32'(n_a), 32'd0);
        chk("lastwin_all_b", 32'(n_b), 32'(4 * (TD - BC)));
        chk("lastwin_single_ack", 32'(ack_seen - a0), 32'd1);

        // Load during the commit cycle stays pending for the next frame
        wait_pos(5);
        load_once(16'h1111, 4'h0, 4'hF);
        wait_pos(0);
        chk("commit_ack1", 32'(bus.load_ack), 32'd1);
        load_once(16'h2222, 4'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            wait_pos(k * TD + 4);
            chk("commit_old_d", 32'(bus.dec_d), 32'h1);
        end
        wait_pos(0);
        chk("commit_ack2", 32'(bus.load_ack), 32'd1);
        wait_pos(4);
        chk("commit_new_d", 32'(bus.dec_d), 32'h2);

        // Reset mid-slot with a load pending
        wait_pos(5);
        load_once(16'h3333, 4'h0, 4'hF);
        wait_pos(2 * TD + 4);
        chk("pre_rst_an", 32'(bus.an), 32'(4'b1011));
        rst_n = 1'b0;
        cyc();
        chk("midrst_an", 32'(bus.an), 32'hF);
        chk("midrst_idx", 32'(bus.digit_idx), 32'd0);
        cyc();
        rst_n = 1'b1;
        a0 = ack_seen;
        repeat (2 * FR) cyc();
        chk("midrst_no_ack", 32'(ack_seen - a0), 32'd0);

        // Load held high: one ack per frame
        wait_pos(1);
        bus.hex_in = 16'h5555;
        bus.dp_in  = 4'h0;
        bus.en_in  = 4'hF;
        bus.load   = 1'b1;
        a0 = ack_seen;
        repeat (2 * FR) cyc();
        bus.load = 1'b0;
        chk("held_load_acks", 32'(ack_seen - a0), 32'd2);
        wait_pos(TD + 4);
        chk("held_load_d", 32'(bus.dec_d), 32'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes one shared hex-to-seven-segment decoder across a 4-digit common-anode display.
- Sequences the decoder inputs D[3:0], point and LE together with the four digit anodes.
- Inserts a blanking gap between digits to prevent ghosting.
- Takes new display data through a load/ack handshake that is frame-synchronous, so a digit never shows a mix of old and new data.

Parameters:
TICK_DIV, 50000, clock cycles per digit slot (BLANK plus SHOW); must be at least 2.
BLANK_CYC, 16, cycles per slot with all anodes off and the decoder blanked; must satisfy 0 <= BLANK_CYC < TICK_DIV.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
hex_in  input  16  digit nibbles; digit k = hex_in[4k+3:4k]
dp_in  input  4  decimal point per digit, 1 = lit
en_in  input  4  digit enable, 0 = digit blanked
load  input  1  request to capture hex_in/dp_in/en_in
load_ack  output  1  one-cycle pulse when captured values become the shadow set
dec_d  output  4  nibble to decoder D3..D0
dec_point  output  1  to decoder point input
dec_le  output  1  to decoder LE input, 1 = blank segments
an  output  4  digit anodes, active-low
digit_idx  output  2  digit currently scanned
frame_start  output  1  one-cycle pulse at the first cycle of digit 0's slot

Behaviour:
- One clock domain, clk. Reset is synchronous and active-low (rst_n); it is sampled only on the rising clk edge.
- While rst_n = 0, on every edge, the block loads:
  - state = BLANK, cnt = 0, digit_idx = 0
  - shadow hex, dp and en = 0; pending = 0
  - outputs: an = 4'b1111, dec_le = 1, dec_d = 0, dec_point = 0, load_ack = 0, frame_start = 0
- Reset asserted mid-slot or mid-handshake aborts immediately; a pending load is discarded.
- Slot counter: cnt runs 0..TICK_DIV-1 and wraps to 0. On wrap, digit_idx increments mod 4 (3 -> 0).
- State machine, two states per slot:
  - BLANK while cnt < BLANK_CYC: an = 1111, dec_le = 1.
  - SHOW while cnt >= BLANK_CYC: an has only bit digit_idx low; dec_d = shadow nibble[digit_idx]; dec_point = shadow dp[digit_idx]; dec_le = ~shadow en[digit_idx].
  - If BLANK_CYC = 0, the BLANK state is never entered.
  - If shadow en[digit_idx] = 0, an still selects the digit but dec_le = 1, so the digit stays dark.
- All outputs are registered and reflect state and cnt of the same cycle; no combinational path from inputs to outputs.
- Frame: a frame is 4*TICK_DIV cycles. frame_start = 1 in every cycle where digit_idx = 0 and cnt = 0, including the first cycle after reset release.
- Load handshake:
  - load = 1 in any cycle sets pending and captures hex_in/dp_in/en_in into a staging register. A later load before commit overwrites the staging data (last value wins).
  - Commit happens at the frame boundary, i.e. the cycle in which frame_start = 1: staging is copied to shadow and load_ack = 1 for that cycle; pending clears.
  - A load in the commit cycle itself is re-captured and stays pending for the next frame.
  - Maximum latency from load to ack is 4*TICK_DIV cycles.
  - load held high continuously produces one ack per frame.
- Shadow changes only at commit, so every digit of a frame comes from the same data set.
- Width rules:
  - cnt width = clog2(TICK_DIV).
  - digit_idx wraps naturally in 2 bits.
  - No output glitches on state change, since all outputs are registered.

Test Plan:
Benches use TICK_DIV = 8, BLANK_CYC = 2.
1. Reset: hold rst_n = 0 for 5 cycles, then release -> an = 1111, dec_le = 1, load_ack = 0 throughout reset; frame_start = 1 on the first released cycle; display stays dark because shadow en = 0.
2. Basic scan: load one cycle with hex_in = 16'h4321, dp_in = 4'b0101, en_in = 4'b1111 -> load_ack at the next frame_start. In the following frame, each slot shows 2 cycles of an = 1111 then 6 cycles with an = 1110/1101/1011/0111, and dec_d = 1, 2, 3, 4 respectively; dec_point = 1 on digits 0 and 2 only.
3. Digit disable: en_in = 4'b1011 -> during digit 2's SHOW, an = 1011 and dec_le = 1; the other digits show dec_le = 0.
4. Last-wins and atomicity: load 16'hAAAA at cnt = 3 of digit 1, then load 16'hBBBB at digit 3 -> a single load_ack at the next frame_start; the next frame shows B on every digit and never A; no change to shadow mid-frame.
5. Load in the commit cycle: load 16'h1111, then assert load with 16'h2222 exactly in the frame_start/ack cycle -> that frame shows 1111; the next frame_start gives a second ack and then 2222.
6. Reset mid-operation: assert rst_n = 0 during digit 2's SHOW with a load pending -> next edge gives an = 1111, digit_idx = 0; after release no load_ack occurs without a new load.
